corr_dump_collector: RTL and testbench

//  Collects correlator dumps from NUM_CH tracking channels into one record stream for the CPU/logger.
//  Per channel: latches the E/P/L I/Q accumulators on dump, computes E/P/L power, flags lock quality.

---
 rtl/corr_dump_collector.sv | 214 +++++++++++++++++++++
 tb/tb_corr_dump_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/corr_dump_collector.sv
// corr_dump_collector
//   Gathers correlator dumps from NUM_CH tracking channels into one record
//   stream. Each channel has a shadow register and a pending flag. A
//   round-robin arbiter picks one pending channel per cycle. A two-stage
//   pipeline computes the E/P/L powers and the lock flag. The records then
//   go into a first-word-fall-through FIFO with a valid/ready output.
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   ch_dump, ch_iq       per-channel dump strobe and {ie,qe,ip,qp,il,ql}
//   rec_valid/rec_ready  record handshake at the FIFO head
//   rec_ch, rec_iq       source channel and latched accumulators
//   rec_pow_p, rec_lock  prompt power and lock-quality flag
//   rec_seq              global record sequence number (assigned at FIFO write)
//   fifo_level           entries held in the FIFO
//   overrun, overrun_clr sticky per-channel overrun flags and their clear

// Per-channel capture: shadow register, pending flag, sticky overrun.
module corr_dump_ch #(
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               dump,
  input  logic [6*ACC_W-1:0] iq,
  input  logic               grant,
  input  logic               overrun_clr,
  output logic               pending,
  output logic [6*ACC_W-1:0] shadow,
  output logic               overrun
);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      shadow  <= '0;
    end else begin
      if (dump) shadow <= iq;
      // A re-dump in the grant cycle keeps the channel pending. The granted
      // record carries the old shadow, so nothing is lost.
      if (dump)       pending <= 1'b1;
      else if (grant) pending <= 1'b0;
      // When a set and a clear arrive in the same cycle, the set wins.
      if (dump && pending && !grant) overrun <= 1'b1;
      else if (overrun_clr)          overrun <= 1'b0;
    end
  end
endmodule

module corr_dump_collector #(
  parameter int NUM_CH         = 12,
  parameter int ACC_W          = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int MIN_PROMPT_POW = 1000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       ch_dump,
  input  logic [NUM_CH*6*ACC_W-1:0] ch_iq,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [CH_W-1:0]         rec_ch,
  output logic [6*ACC_W-1:0]      rec_iq,
  output logic [2*ACC_W-1:0]      rec_pow_p,
  output logic                    rec_lock,
  output logic [15:0]             rec_seq,
  output logic [LVL_W-1:0]        fifo_level,
  output logic [NUM_CH-1:0]       overrun,
  input  logic                    overrun_clr
);
  localparam int IQ_W   = 6*ACC_W;
  localparam int SQ_W   = 2*ACC_W - 1;
  localparam int POW_W  = 2*ACC_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [IQ_W-1:0]  iq;
    logic [POW_W-1:0] pow_p;
    logic             lock;
    logic [15:0]      seq;
  } rec_t;

  // Returns the exact square of a signed value. (-2^(ACC_W-1))^2 still
  // fits in 2*ACC_W-1 bits.
  function automatic logic [SQ_W-1:0] sq(input logic [ACC_W-1:0] a);
    logic signed [2*ACC_W-1:0] ax;
    ax = {{ACC_W{a[ACC_W-1]}}, a};
    return SQ_W'(ax * ax);
  endfunction

  logic [NUM_CH-1:0]            pending, gnt_vec;
  logic [NUM_CH-1:0][IQ_W-1:0]  shadow;
  logic [CH_W-1:0]              rr_ptr, gnt_idx;
  logic                         gnt_any, room;
  logic [STAGES:1]              vld_pipe;
  logic [LVL_W-1:0]             count;
  logic [LVL_W:0]               occ;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    corr_dump_ch #(.ACC_W(ACC_W)) u_ch (
      .clk(clk), .rstn(rstn), .dump(ch_dump[k]), .iq(ch_iq[k*IQ_W +: IQ_W]),
      .grant(gnt_vec[k]), .overrun_clr(overrun_clr),
      .pending(pending[k]), .shadow(shadow[k]), .overrun(overrun[k])
    );
  end

  // Records already in S1/S2 count against FIFO space, so a push can never
  // land on a full FIFO.
  assign occ  = {1'b0, count} + {{LVL_W{1'b0}}, vld_pipe[1]} + {{LVL_W{1'b0}}, vld_pipe[2]};
  assign room = occ < (LVL_W+1)'(FIFO_DEPTH);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_any && room && pending[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn)        rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
  end

  // S1: the six squares of the granted shadow. Field 0 is ie, field 5 is ql.
  logic [IQ_W-1:0]            sel_iq, s1_iq, s2_iq;
  logic [5:0][ACC_W-1:0]      fld;
  logic [5:0][SQ_W-1:0]       s1_sq;
  logic [CH_W-1:0]            s1_ch, s2_ch;
  logic [POW_W-1:0]           pow_e, pow_p, pow_l, s2_pow;
  logic                       s2_lock;

  assign sel_iq = shadow[gnt_idx];
  for (genvar j = 0; j < 6; j++) begin : g_fld
    assign fld[j] = sel_iq[(5-j)*ACC_W +: ACC_W];
  end

  always_ff @(posedge clk) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
  end

  always_ff @(posedge clk) begin
    s1_ch <= gnt_idx;
    s1_iq <= sel_iq;
    for (int j = 0; j < 6; j++) s1_sq[j] <= sq(fld[j]);
  end

  // S2: the three power sums and the lock compare.
  assign pow_e = {1'b0, s1_sq[0]} + {1'b0, s1_sq[1]};
  assign pow_p = {1'b0, s1_sq[2]} + {1'b0, s1_sq[3]};
  assign pow_l = {1'b0, s1_sq[4]} + {1'b0, s1_sq[5]};

  always_ff @(posedge clk) begin
    s2_ch   <= s1_ch;
    s2_iq   <= s1_iq;
    s2_pow  <= pow_p;
    s2_lock <= (pow_p >= pow_e) && (pow_p >= pow_l) && (pow_p >= POW_W'(MIN_PROMPT_POW));
  end

  // FIFO with first-word fall-through. Head fields are forced to 0 while
  // the FIFO is empty, so the storage itself needs no reset.
  rec_t             mem [FIFO_DEPTH];
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      seq;
  logic             push, pop;

  assign push = vld_pipe[STAGES];
  assign pop  = rec_valid && rec_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ch: s2_ch, iq: s2_iq, pow_p: s2_pow, lock: s2_lock, seq: seq};
  end

  assign head       = mem[rd_ptr];
  assign rec_valid  = (count != '0);
  assign fifo_level = count;
  assign rec_ch     = rec_valid ? head.ch    : '0;
  assign rec_iq     = rec_valid ? head.iq    : '0;
  assign rec_pow_p  = rec_valid ? head.pow_p : '0;
  assign rec_lock   = rec_valid ? head.lock  : 1'b0;
  assign rec_seq    = rec_valid ? head.seq   : '0;
endmodule

// File: tb/tb_corr_dump_collector.sv
module tb_corr_dump_collector;
  localparam int NUM_CH = 12, ACC_W = 16, FIFO_DEPTH = 16, IQ_W = 6*ACC_W;

  logic                   clk, rstn, rec_valid, rec_ready, rec_lock, overrun_clr;
  logic [NUM_CH-1:0]      ch_dump, overrun;
  logic [NUM_CH*IQ_W-1:0] ch_iq;
  logic [3:0]             rec_ch;
  logic [IQ_W-1:0]        rec_iq;
  logic [2*ACC_W-1:0]     rec_pow_p;
  logic [15:0]            rec_seq;
  logic [4:0]             fifo_level;

  corr_dump_collector #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH), .MIN_PROMPT_POW(1000)) dut (
    .clk(clk), .rstn(rstn), .ch_dump(ch_dump), .ch_iq(ch_iq),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ch(rec_ch), .rec_iq(rec_iq),
    .rec_pow_p(rec_pow_p), .rec_lock(rec_lock), .rec_seq(rec_seq),
    .fifo_level(fifo_level), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, exp_seq = 0;

  typedef struct {
    int          ch;
    logic [95:0] iq;
    logic [31:0] pow;
    logic        lock;
    int          seq;
  } exp_t;
  exp_t sb[$];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pk(input int ie, qe, ip, qp, il, ql);
    return {16'(ie), 16'(qe), 16'(ip), 16'(qp), 16'(il), 16'(ql)};
  endfunction

  task automatic load(input int ch, input logic [95:0] v);
    ch_iq[ch*IQ_W +: IQ_W] = v;
    ch_dump[ch] = 1'b1;
  endtask

  task automatic push(input int ch, input logic [95:0] v, input logic [31:0] pow, input logic lock);
    sb.push_back('{ch, v, pow, lock, exp_seq});
    exp_seq = (exp_seq + 1) & 16'hFFFF;
  endtask

  // Applies the loaded dumps at the next edge, then drops the strobes.
  task automatic fire;
    tick;
    ch_dump = '0;
    overrun_clr = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((sb.size() != 0 || rec_valid) && n < bound) begin
      tick;
      n++;
    end
    tests++;
    if (n >= bound) begin
      fails++;
      $display("FAIL %s: drain timeout, %0d records still expected", name, sb.size());
    end
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    sb.delete();
    exp_seq = 0;
  endtask

  // Scoreboard monitor. A handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (rstn && rec_valid && rec_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_record: ch=%0d seq=%0d", rec_ch, rec_seq);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rec_ch !== 4'(e.ch) || rec_iq !== e.iq || rec_pow_p !== e.pow ||
            rec_lock !== e.lock || rec_seq !== 16'(e.seq)) begin
          fails++;
          $display("FAIL record: got ch=%0d pow=%0d lock=%0b seq=%0d iq=%h expected ch=%0d pow=%0d lock=%0b seq=%0d iq=%h",
                   rec_ch, rec_pow_p, rec_lock, rec_seq, rec_iq, e.ch, e.pow, e.lock, e.seq, e.iq);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; ch_dump = '0; ch_iq = '0; rec_ready = 1'b0; overrun_clr = 1'b0;
    tick; tick;
    check("rst_valid", rec_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pow", rec_pow_p, 0);
    rstn = 1'b1;
    tick;

    // Single dump on ch3, with the latency checked cycle by cycle.
    rec_ready = 1'b1;
    load(3, pk(10, 0, 100, -50, 10, 0));
    push(3, pk(10, 0, 100, -50, 10, 0), 12500, 1'b1);
    fire;
    check("lat_e0", rec_valid, 0);
    tick; check("lat_e1", rec_valid, 0);
    tick; check("lat_e2", rec_valid, 0);
    tick; check("lat_e3", rec_valid, 1);
    wait_drain("ch3", 20);

    // All channels dump in the same cycle after a reset.
    do_reset;
    for (int c = 0; c < NUM_CH; c++) begin
      load(c, pk(0, 0, c*100, 0, 0, 0));
      push(c, pk(0, 0, c*100, 0, 0, 0), c*c*10000, c >= 1);
    end
    fire;
    wait_drain("all12", 60);
    check("all12_overrun", overrun, 0);

    // Fill the FIFO with rec_ready low, then trigger overrun on ch5.
    do_reset;
    rec_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      load(c, pk(0, 0, c*100, 0, 0, 0));
      push(c, pk(0, 0, c*100, 0, 0, 0), c*c*10000, c >= 1);
    end
    fire;
    repeat (20) tick;
    check("fill12_level", fifo_level, 12);
    for (int c = 0; c < 4; c++) begin
      load(c, pk(0, 0, 0, 40*(c+1), 0, 0));
      push(c, pk(0, 0, 0, 40*(c+1), 0, 0), 1600*(c+1)*(c+1), 1'b1);
    end
    fire;
    repeat (20) tick;
    check("full_level", fifo_level, 16);
    check("hold_ch", rec_ch, 0);
    check("hold_seq", rec_seq, 0);
    load(5, pk(0, 0, 1, 0, 0, 0));
    load(6, pk(5, 0, 0, 0, 0, 0));
    load(7, pk(0, 0, 50, 0, 0, 0));
    fire;
    check("first_dump_no_ovr", overrun, 0);
    load(5, pk(0, 0, 2, 0, 0, 0));
    fire;
    check("ovr5_set", overrun, 12'h020);
    overrun_clr = 1'b1;
    fire;
    check("ovr_clr", overrun, 0);
    load(5, pk(0, 0, -100, -100, 0, 0));
    overrun_clr = 1'b1;
    fire;
    check("ovr_set_wins", overrun, 12'h020);
    overrun_clr = 1'b1;
    fire;
    check("ovr_clr2", overrun, 0);
    repeat (5) tick;
    check("still_full", fifo_level, 16);
    check("hold_seq2", rec_seq, 0);
    push(5, pk(0, 0, -100, -100, 0, 0), 20000, 1'b1);
    push(6, pk(5, 0, 0, 0, 0, 0), 0, 1'b0);
    push(7, pk(0, 0, 50, 0, 0, 0), 2500, 1'b1);
    rec_ready = 1'b1;
    wait_drain("release", 80);
    check("release_overrun", overrun, 0);

    // Lock-flag corner cases and the full-scale square.
    load(1, pk(0, 0, 20, 20, 0, 0));
    push(1, pk(0, 0, 20, 20, 0, 0), 800, 1'b0);
    fire; wait_drain("pow800", 20);
    load(2, pk(200, 0, 100, 0, 0, 0));
    push(2, pk(200, 0, 100, 0, 0, 0), 10000, 1'b0);
    fire; wait_drain("early_gt", 20);
    load(10, pk(0, 0, 30, 40, 0, 60));
    push(10, pk(0, 0, 30, 40, 0, 60), 2500, 1'b0);
    fire; wait_drain("late_gt", 20);
    load(9, pk(0, 0, -32768, -32768, 0, 0));
    push(9, pk(0, 0, -32768, -32768, 0, 0), 32'h8000_0000, 1'b1);
    fire; wait_drain("max_neg", 20);

    // Reset while the FIFO holds 5 records and ch4 shows an overrun.
    do_reset;
    rec_ready = 1'b0;
    for (int c = 0; c < 5; c++) load(c, pk(0, 0, c+1, 0, 0, 0));
    fire;
    load(4, pk(0, 0, 9, 0, 0, 0));
    fire;
    repeat (10) tick;
    check("pre_rst_level", fifo_level, 5);
    check("pre_rst_ovr", overrun, 12'h010);
    rstn = 1'b0;
    tick;
    check("mid_rst_valid", rec_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovr", overrun, 0);
    rstn = 1'b1;
    sb.delete();
    exp_seq = 0;
    repeat (5) tick;
    check("post_rst_idle", rec_valid, 0);
    rec_ready = 1'b1;
    load(2, pk(0, 0, 0, -40, 0, 0));
    push(2, pk(0, 0, 0, -40, 0, 0), 1600, 1'b1);
    fire;
    wait_drain("seq_restart", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
